// File: rtl/sdram_cmd_issuer.sv
// SDRAM command issuer: registered pins, global hold-off counter.
// Define SDRAM_ROW_TRACK_EN for per-bank open-row checking.
module sdram_cmd_issuer #(
  parameter int BA_W  = 2,
  parameter int ROW_W = 13,
  parameter int COL_W = 9,
  parameter int T_RCD = 2,
  parameter int T_RP  = 2,
  parameter int T_RFC = 7,
  parameter int T_WR  = 2,
  parameter int T_MRD = 2,
  parameter int ADDR_W = BA_W + ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ROW_W-1:0]  sdram_addr,
  output logic              busy,
  output logic              err_cmd
);

  localparam int CNT_W = 8;
  localparam int NB = 1 << BA_W;
  localparam logic [ROW_W-1:0] A10 = ROW_W'(1 << 10);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PALL = 3'd5;
  localparam logic [2:0] OP_REF  = 3'd6;
  localparam logic [2:0] OP_LMR  = 3'd7;

  logic             cke_r;
  logic [CNT_W-1:0] cnt;
  logic [BA_W-1:0]  bank;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] col_a;
  logic             accept;
  logic             bad;
  logic             issue;

  logic [3:0]       pin_n;
  logic [BA_W-1:0]  ba_n;
  logic [ROW_W-1:0] addr_n;
  logic [CNT_W-1:0] ld;

  assign {bank, row, col} = cmd_addr;
  assign col_a = ROW_W'(col) & ~A10;
  assign cmd_ready = cke_r && (cnt == '0);
  assign busy = (cnt != '0);
  assign accept = cmd_valid && cmd_ready;
  assign issue = accept && !bad;
  assign sdram_cke = cke_r;

`ifdef SDRAM_ROW_TRACK_EN
  logic [NB-1:0]    open_q;
  logic [ROW_W-1:0] row_q [NB];
  logic             err_r;

  always_comb begin
    bad = 1'b0;
    unique case (cmd_op)
      OP_ACT:        bad = open_q[bank];
      OP_RD, OP_WR:  bad = !open_q[bank] || (row_q[bank] != row);
      OP_REF, OP_LMR: bad = |open_q;
      default:       bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
      err_r  <= 1'b0;
    end else begin
      err_r <= accept && bad;
      if (issue) begin
        unique case (cmd_op)
          OP_ACT:  open_q[bank] <= 1'b1;
          OP_PRE:  open_q[bank] <= 1'b0;
          OP_PALL: open_q <= '0;
          default: ;
        endcase
      end
    end
  end

  // Row contents only matter while the bank flag is set.
  always_ff @(posedge clk) begin
    if (issue && cmd_op == OP_ACT)
      row_q[bank] <= row;
  end

  assign err_cmd = err_r;
`else
  assign bad = 1'b0;
  assign err_cmd = 1'b0;
`endif

  always_comb begin
    pin_n  = 4'b0111;
    ba_n   = '1;
    addr_n = '1;
    ld     = '0;
    if (issue) begin
      unique case (cmd_op)
        OP_ACT: begin
          pin_n = 4'b0011; ba_n = bank; addr_n = row;
          ld = CNT_W'(T_RCD - 1);
        end
        OP_RD: begin
          pin_n = 4'b0101; ba_n = bank; addr_n = col_a;
        end
        OP_WR: begin
          pin_n = 4'b0100; ba_n = bank; addr_n = col_a;
          ld = CNT_W'(T_WR - 1);
        end
        OP_PRE: begin
          pin_n = 4'b0010; ba_n = bank; addr_n = '0;
          ld = CNT_W'(T_RP - 1);
        end
        OP_PALL: begin
          pin_n = 4'b0010; addr_n = A10;
          ld = CNT_W'(T_RP - 1);
        end
        OP_REF: begin
          pin_n = 4'b0001;
          ld = CNT_W'(T_RFC - 1);
        end
        OP_LMR: begin
          pin_n = 4'b0000; ba_n = '0;
          addr_n = cmd_addr[ROW_W-1:0];
          ld = CNT_W'(T_MRD - 1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cke_r <= 1'b0;
      cnt   <= '0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= 4'b1111;
      sdram_ba   <= '1;
      sdram_addr <= '1;
    end else begin
      cke_r <= 1'b1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= pin_n;
      sdram_ba   <= ba_n;
      sdram_addr <= addr_n;
      if (issue)
        cnt <= ld;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_issuer.sv
// Bench for sdram_cmd_issuer: directed sequence plus random traffic
// checked against a cycle-count reference model.
module tb_sdram_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [23:0] cmd_addr = '0;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic        busy, err_cmd;

  sdram_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .busy(busy), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: cycle count since reset release and the first
  // cycle at which a new command may be accepted.
  int  cyc = 0;
  int  ready_at = 0;
  bit  inited = 0;
  bit  last_acc = 0;
  bit  open_b [4];
  int  open_r [4];
  int  sp [8] = '{1, 2, 1, 2, 2, 2, 7, 2};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [2:0] op, input logic [23:0] a);
    int b = int'(a[23:22]);
    int r = int'(a[21:9]);
    bit any = open_b[0] | open_b[1] | open_b[2] | open_b[3];
    is_bad = 0;
`ifdef SDRAM_ROW_TRACK_EN
    case (op)
      3'd1: is_bad = open_b[b];
      3'd2, 3'd3: is_bad = !open_b[b] || open_r[b] != r;
      3'd6, 3'd7: is_bad = any;
      default: is_bad = 0;
    endcase
`else
    if (b < 0 || r < 0 || any) is_bad = 0;
`endif
  endfunction

  task automatic pin_exp(input logic [2:0] op, input logic [23:0] a,
                         output logic [3:0] code, output logic [1:0] ba,
                         output logic [12:0] ad);
    code = 4'b0111; ba = 2'b11; ad = 13'h1fff;
    case (op)
      3'd1: begin code = 4'b0011; ba = a[23:22]; ad = a[21:9]; end
      3'd2: begin code = 4'b0101; ba = a[23:22]; ad = {4'b0, a[8:0]}; end
      3'd3: begin code = 4'b0100; ba = a[23:22]; ad = {4'b0, a[8:0]}; end
      3'd4: begin code = 4'b0010; ba = a[23:22]; ad = 13'h0; end
      3'd5: begin code = 4'b0010; ad = 13'h0400; end
      3'd6: code = 4'b0001;
      3'd7: begin code = 4'b0000; ba = 2'b00; ad = a[12:0]; end
      default: ;
    endcase
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] op,
                      input logic [23:0] a);
    bit exp_rdy, acc, bd;
    logic [3:0] code;
    logic [1:0] eba;
    logic [12:0] ead;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_addr = a;
    exp_rdy = (cyc >= 1) && (cyc >= ready_at);
    if (inited) chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_rdy});
    acc = !r && v && exp_rdy;
    bd = acc && is_bad(op, a);
    @(posedge clk);
    #1;
    if (r) begin
      cyc = 0; ready_at = 0; inited = 1;
      for (int i = 0; i < 4; i++) open_b[i] = 0;
      chk("rst_pins", {27'b0, sdram_cke, sdram_cs_n, sdram_ras_n,
          sdram_cas_n, sdram_we_n}, 32'h0f);
      chk("rst_ba", {30'b0, sdram_ba}, 32'h3);
      chk("rst_addr", {19'b0, sdram_addr}, 32'h1fff);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_err", {31'b0, err_cmd}, 32'h0);
    end else begin
      cyc++;
      pin_exp(3'd0, a, code, eba, ead);
      if (acc && !bd) begin
        pin_exp(op, a, code, eba, ead);
        ready_at = cyc + sp[op] - 1;
        if (op == 3'd1) begin
          open_b[a[23:22]] = 1; open_r[a[23:22]] = int'(a[21:9]);
        end
        if (op == 3'd4) open_b[a[23:22]] = 0;
        if (op == 3'd5) for (int i = 0; i < 4; i++) open_b[i] = 0;
      end
      chk("pins", {27'b0, sdram_cke, sdram_cs_n, sdram_ras_n,
          sdram_cas_n, sdram_we_n}, {27'b0, 1'b1, code});
      chk("ba", {30'b0, sdram_ba}, {30'b0, eba});
      chk("addr", {19'b0, sdram_addr}, {19'b0, ead});
      chk("busy", {31'b0, busy}, {31'b0, cyc < ready_at});
      chk("err", {31'b0, err_cmd}, {31'b0, bd});
    end
    last_acc = acc;
  endtask

  // Hold a command valid until it is accepted, bounded.
  task automatic issue(input logic [2:0] op, input logic [23:0] a);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b0, 1'b1, op, a);
      done = last_acc;
    end
    chk("accept_timeout", {31'b0, done}, 32'h1);
  endtask

  initial begin
    step(1'b1, 1'b0, 3'd0, '0);
    step(1'b1, 1'b0, 3'd0, '0);
    step(1'b0, 1'b0, 3'd0, '0);
    issue(3'd5, '0);
    issue(3'd6, '0);
    issue(3'd7, 24'h000037);
    issue(3'd1, {2'b01, 13'h0123, 9'h045});
    issue(3'd2, {2'b01, 13'h0123, 9'h045});
    issue(3'd3, {2'b01, 13'h0123, 9'h045});
    issue(3'd4, {2'b01, 13'h0123, 9'h045});
    step(1'b0, 1'b0, 3'd0, '0);
`ifdef SDRAM_ROW_TRACK_EN
    issue(3'd2, {2'b10, 13'h0, 9'h0});
    issue(3'd1, {2'b00, 13'h5, 9'h0});
    issue(3'd3, {2'b00, 13'h6, 9'h0});
    issue(3'd5, '0);
`endif
    issue(3'd6, '0);
    step(1'b1, 1'b0, 3'd0, '0);
    step(1'b0, 1'b0, 3'd0, '0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)), 24'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
